// File: rtl/inst_fetcher.sv
// Front-end fetch: reads a byte-wide memory and assembles 32-bit little-endian instructions into a {pc, inst} queue.
// Latency: 2 cycles/byte with a 1-cycle memory, so 8 cycles/instruction; the head is visible the cycle after the last byte.
// Backpressure: fetch pauses when the queue is full and resumes on the edge a pop frees a slot; flush redirects at once.
module inst_fetcher #(
    parameter int          QUEUE_DEPTH_LOG = 2,
    parameter logic [31:0] RESET_PC        = 32'h0
) (
    input  logic        clk_in,
    input  logic        rst_in,
    output logic        mem_req,
    output logic [31:0] mem_addr,
    input  logic        mem_valid,
    input  logic [7:0]  mem_data,
    input  logic        flush_in,
    input  logic [31:0] flush_pc,
    output logic        inst_valid,
    output logic [31:0] inst_out,
    output logic [31:0] pc_out,
    input  logic        inst_ready
);

    localparam int DEPTH = 1 << QUEUE_DEPTH_LOG;
    localparam logic [QUEUE_DEPTH_LOG:0] DEPTH_CNT = {1'b1, {QUEUE_DEPTH_LOG{1'b0}}};

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,  // no request outstanding
        S_WAIT  = 2'd1,  // request outstanding, its byte will be kept
        S_DRAIN = 2'd2   // request outstanding, its byte belongs to a flushed stream
    } state_t;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] inst;
    } entry_t;

    state_t state, state_nxt;

    logic [31:0] fetch_pc, fetch_pc_nxt;
    logic [1:0]  byte_cnt, byte_cnt_nxt;
    logic [23:0] inst_buf;

    entry_t                     queue_mem [DEPTH];
    logic [QUEUE_DEPTH_LOG-1:0] wr_ptr, rd_ptr;
    logic [QUEUE_DEPTH_LOG:0]   count, count_nxt;

    logic        byte_done;
    logic        push, pop;
    logic        room;
    logic        issue;
    logic [31:0] addr_nxt;

    // Queue bookkeeping and fetch-position update for this edge; flush overrides everything.
    always_comb begin
        byte_done    = (state == S_WAIT) && mem_valid;
        pop          = inst_valid && inst_ready && !flush_in;
        push         = byte_done && (byte_cnt == 2'd3) && !flush_in &&
                       ((count != DEPTH_CNT) || pop);
        count_nxt    = flush_in ? '0 :
                       count + {{QUEUE_DEPTH_LOG{1'b0}}, push} - {{QUEUE_DEPTH_LOG{1'b0}}, pop};
        room         = (count_nxt != DEPTH_CNT);
        fetch_pc_nxt = fetch_pc;
        byte_cnt_nxt = byte_cnt;
        if (flush_in) begin
            fetch_pc_nxt = flush_pc;
            byte_cnt_nxt = 2'd0;
        end else if (byte_done) begin
            if (byte_cnt == 2'd3) begin
                fetch_pc_nxt = fetch_pc + 32'd4;
                byte_cnt_nxt = 2'd0;
            end else begin
                byte_cnt_nxt = byte_cnt + 2'd1;
            end
        end
    end

    // State register.
    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) state <= S_IDLE;
        else        state <= state_nxt;
    end

    // Next-state logic; a flush empties the queue, so room is always true on a flush edge.
    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE:  state_nxt = room ? S_WAIT : S_IDLE;
            S_WAIT: begin
                if (mem_valid)     state_nxt = room ? S_WAIT : S_IDLE;
                else if (flush_in) state_nxt = S_DRAIN;
            end
            // A stale response arriving together with a further flush still ends the drain,
            // otherwise nothing would ever leave DRAIN again.
            S_DRAIN: if (mem_valid) state_nxt = S_WAIT;
            default: state_nxt = S_IDLE;
        endcase
    end

    // A new request is launched on every entry into WAIT, or on a WAIT->WAIT edge that retires a byte.
    always_comb begin
        issue    = (state_nxt == S_WAIT) && ((state != S_WAIT) || mem_valid);
        addr_nxt = fetch_pc_nxt + {30'b0, byte_cnt_nxt};
    end

    // Fetch position, partial instruction and registered memory request.
    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) begin
            fetch_pc <= RESET_PC;
            byte_cnt <= 2'd0;
            inst_buf <= '0;
            mem_req  <= 1'b0;
            mem_addr <= RESET_PC;
        end else begin
            fetch_pc <= fetch_pc_nxt;
            byte_cnt <= byte_cnt_nxt;
            mem_req  <= issue;
            if (issue) mem_addr <= addr_nxt;
            if (byte_done && !flush_in) begin
                case (byte_cnt)
                    2'd0:    inst_buf[7:0]   <= mem_data;
                    2'd1:    inst_buf[15:8]  <= mem_data;
                    2'd2:    inst_buf[23:16] <= mem_data;
                    default: ;
                endcase
            end
        end
    end

    // Queue pointers and occupancy; pointers wrap naturally at DEPTH.
    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            count <= count_nxt;
            if (flush_in) begin
                wr_ptr <= '0;
                rd_ptr <= '0;
            end else begin
                if (push) wr_ptr <= wr_ptr + 1'b1;
                if (pop)  rd_ptr <= rd_ptr + 1'b1;
            end
        end
    end

    // Queue storage; the last byte goes straight in alongside the three buffered ones.
    always_ff @(posedge clk_in) begin
        if (push) queue_mem[wr_ptr] <= '{pc: fetch_pc, inst: {mem_data, inst_buf}};
    end

    assign inst_valid = (count != '0);
    assign inst_out   = inst_valid ? queue_mem[rd_ptr].inst : 32'h0;
    assign pc_out     = inst_valid ? queue_mem[rd_ptr].pc   : 32'h0;

endmodule

// File: tb/tb_inst_fetcher.sv
// Bench for inst_fetcher: byte memory with programmable latency, scoreboard of expected {pc, inst} in fetch order.
// Latency: checks first-instruction timing, refill timing after a pop, and flush/drain request timing.
// Backpressure: inst_ready is held low to fill the queue and pulsed to exercise pop-with-push.
module tb_inst_fetcher;

    logic        clk_in = 1'b0;
    logic        rst_in = 1'b1;
    logic        mem_req;
    logic [31:0] mem_addr;
    logic        mem_valid = 1'b0;
    logic [7:0]  mem_data = 8'h0;
    logic        flush_in = 1'b0;
    logic [31:0] flush_pc = 32'h0;
    logic        inst_valid;
    logic [31:0] inst_out;
    logic [31:0] pc_out;
    logic        inst_ready = 1'b0;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] inst;
    } exp_t;

    exp_t        sb[$];
    logic [31:0] req_addrs[$];
    int          checks   = 0;
    int          failures = 0;
    int          lat      = 1;

    inst_fetcher #(.QUEUE_DEPTH_LOG(2), .RESET_PC(32'h0)) dut (
        .clk_in     (clk_in),
        .rst_in     (rst_in),
        .mem_req    (mem_req),
        .mem_addr   (mem_addr),
        .mem_valid  (mem_valid),
        .mem_data   (mem_data),
        .flush_in   (flush_in),
        .flush_pc   (flush_pc),
        .inst_valid (inst_valid),
        .inst_out   (inst_out),
        .pc_out     (pc_out),
        .inst_ready (inst_ready)
    );

    always #5 clk_in = ~clk_in;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    function automatic logic [7:0] mem_byte(input logic [31:0] a);
        case (a)
            32'd0:   return 8'h13;
            32'd1:   return 8'h05;
            32'd2:   return 8'h10;
            32'd3:   return 8'h00;
            default: return (a[7:0] ^ 8'hC3) + {6'b0, a[9:8]};
        endcase
    endfunction

    function automatic logic [31:0] mem_word(input logic [31:0] pc);
        return {mem_byte(pc + 32'd3), mem_byte(pc + 32'd2), mem_byte(pc + 32'd1), mem_byte(pc)};
    endfunction

    function automatic logic [31:0] req_at(input int i);
        return (req_addrs.size() > i) ? req_addrs[i] : 32'hDEAD_DEAD;
    endfunction

    // Expected stream after a (re)start: consecutive words from pc onward.
    task automatic sb_restart(input logic [31:0] pc);
        sb.delete();
        for (int i = 0; i < 24; i++) sb.push_back('{pc: pc + 32'(4 * i), inst: mem_word(pc + 32'(4 * i))});
    endtask

    task automatic step();
        @(posedge clk_in);
        #1;
    endtask

    task automatic wait_req(input string tag);
        int n = 0;
        while (!mem_req && n < 50) begin
            step();
            n++;
        end
        check(tag, 32'(mem_req), 32'd1);
    endtask

    task automatic wait_valid(input string tag);
        int n = 0;
        while (!inst_valid && n < 100) begin
            step();
            n++;
        end
        check(tag, 32'(inst_valid), 32'd1);
    endtask

    task automatic do_reset(input int lat_v, input logic rdy);
        @(posedge clk_in);
        #3;
        rst_in     = 1'b1;
        flush_in   = 1'b0;
        inst_ready = rdy;
        lat        = lat_v;
        sb.delete();
        req_addrs.delete();
        step();
        check("rst_mem_req", 32'(mem_req), 32'd0);
        check("rst_mem_addr", mem_addr, 32'h0);
        check("rst_inst_valid", 32'(inst_valid), 32'd0);
        check("rst_inst_out", inst_out, 32'h0);
        check("rst_pc_out", pc_out, 32'h0);
        step();
        rst_in = 1'b0;
        sb_restart(32'h0);
    endtask

    // Memory: one response per request, lat cycles after the request cycle.
    initial begin
        logic        pend = 1'b0;
        logic [31:0] pend_addr = 32'h0;
        int          dly = 0;
        forever begin
            @(posedge clk_in);
            #1;
            mem_valid = 1'b0;
            if (rst_in) begin
                pend = 1'b0;
            end else begin
                if (pend) begin
                    dly--;
                    if (dly == 0) begin
                        mem_valid = 1'b1;
                        mem_data  = mem_byte(pend_addr);
                        pend      = 1'b0;
                    end
                end
                if (mem_req) begin
                    check("one_outstanding", 32'(pend), 32'd0);
                    pend      = 1'b1;
                    pend_addr = mem_addr;
                    dly       = lat;
                end
            end
        end
    end

    // Monitor: log requests and score every accepted head entry.
    initial begin
        forever begin
            @(negedge clk_in);
            if (!rst_in) begin
                if (mem_req) req_addrs.push_back(mem_addr);
                if (inst_valid && inst_ready && !flush_in) begin
                    check("sb_has_entry", 32'(sb.size() > 0), 32'd1);
                    if (sb.size() > 0) begin
                        exp_t e;
                        e = sb.pop_front();
                        check("pop_pc", pc_out, e.pc);
                        check("pop_inst", inst_out, e.inst);
                    end
                end
            end
        end
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish checks=%0d failures=%0d", checks, failures + 1);
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        int idx;

        // Basic fetch, latency and address sequence.
        do_reset(1, 1'b1);
        wait_req("t1_first_req");
        n = 0;
        while (!inst_valid && n < 50) begin
            step();
            n++;
        end
        check("t1_latency", 32'(n), 32'd8);
        check("t1_inst", inst_out, 32'h00100513);
        check("t1_pc", pc_out, 32'h0);
        repeat (30) step();
        for (int i = 0; i < 5; i++) check("t1_addr_seq", req_at(i), 32'(i));

        // Fill the queue, pop once, then push and pop together at count 3.
        do_reset(1, 1'b0);
        repeat (60) step();
        check("t2_req_count", 32'(req_addrs.size()), 32'd16);
        check("t2_full_no_req", 32'(mem_req), 32'd0);
        check("t2_head_pc", pc_out, 32'h0);
        inst_ready = 1'b1;
        step();
        inst_ready = 1'b0;
        check("t2_refetch_req", 32'(mem_req), 32'd1);
        check("t2_refetch_addr", mem_addr, 32'd16);
        check("t2_next_head", pc_out, 32'd4);
        repeat (7) step();
        check("t2_head_before", pc_out, 32'd4);
        inst_ready = 1'b1;
        step();
        inst_ready = 1'b0;
        check("t2_pushpop_req", 32'(mem_req), 32'd1);
        check("t2_pushpop_addr", mem_addr, 32'd20);
        check("t2_pushpop_head", pc_out, 32'd8);
        inst_ready = 1'b1;
        repeat (80) step();

        // Flush two bytes into pc 8, while the byte-2 response arrives.
        do_reset(1, 1'b0);
        wait_req("t3_first_req");
        repeat (21) step();
        check("t3_valid_before", 32'(inst_valid), 32'd1);
        check("t3_addr_before", mem_addr, 32'd10);
        flush_in = 1'b1;
        flush_pc = 32'h100;
        sb_restart(32'h100);
        idx = req_addrs.size();
        step();
        flush_in = 1'b0;
        check("t3_valid_after", 32'(inst_valid), 32'd0);
        check("t3_req_after", 32'(mem_req), 32'd1);
        check("t3_addr_after", mem_addr, 32'h100);
        inst_ready = 1'b1;
        wait_valid("t3_refill");
        check("t3_new_pc", pc_out, 32'h100);
        repeat (30) step();
        for (int i = 0; i < 4; i++) check("t3_addr_seq", req_at(idx + i), 32'h100 + 32'(i));

        // Latency 3: flush while a request is outstanding, reflush inside DRAIN.
        do_reset(3, 1'b1);
        wait_req("t4_first_req");
        step();
        flush_in = 1'b1;
        flush_pc = 32'h200;
        sb.delete();
        check("t4_no_req_c1", 32'(mem_req), 32'd0);
        step();
        flush_pc = 32'h300;
        sb_restart(32'h300);
        check("t4_no_req_c2", 32'(mem_req), 32'd0);
        step();
        flush_in = 1'b0;
        check("t4_no_req_c3", 32'(mem_req), 32'd0);
        step();
        check("t4_req_after_drain", 32'(mem_req), 32'd1);
        check("t4_addr_after_drain", mem_addr, 32'h300);
        repeat (80) step();

        // Asynchronous reset with byte_cnt=2 of pc 4.
        do_reset(1, 1'b0);
        wait_req("t6_first_req");
        repeat (12) step();
        check("t6_req_mid", 32'(mem_req), 32'd1);
        check("t6_addr_mid", mem_addr, 32'd6);
        check("t6_valid_mid", 32'(inst_valid), 32'd1);
        #2;
        rst_in = 1'b1;
        sb.delete();
        #1;
        check("t6_async_valid", 32'(inst_valid), 32'd0);
        check("t6_async_req", 32'(mem_req), 32'd0);
        check("t6_async_addr", mem_addr, 32'h0);
        check("t6_async_pc", pc_out, 32'h0);
        step();
        rst_in     = 1'b0;
        inst_ready = 1'b1;
        req_addrs.delete();
        sb_restart(32'h0);
        wait_req("t6_restart_req");
        check("t6_restart_addr", mem_addr, 32'h0);
        repeat (40) step();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
